// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared constants for the DDS output path. Holds the default
//                DAC sample width, the SPI frame-length helper, the DAC
//                serialiser state encoding and the DAC control-bit commands.
//  Revision    : 1.0  initial release
// ============================================================================
package dds_pkg;

    // Default sample width of the DDS sine output / DAC input
    localparam int DAC_WIDTH_DEF = 12;
    localparam int CMD_BITS_DEF  = 4;

    // DAC control bits prepended to each sample (PD1/PD0 in the low two bits)
    localparam logic [3:0] CMD_NORMAL  = 4'b0000;
    localparam logic [3:0] CMD_PD_1K   = 4'b0001;
    localparam logic [3:0] CMD_PD_100K = 4'b0010;
    localparam logic [3:0] CMD_PD_HIZ  = 4'b0011;

    // Serialiser states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Total bits in one SPI frame: control bits followed by the sample
    function automatic int frame_bits(input int cmd_bits, input int dac_width);
        return cmd_bits + dac_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_sclk_gen
//  Description : SPI clock generator for the DAC serialiser. Toggles the SPI
//                clock every SCLK_DIV enabled cycles, starting from high.
//                The tick outputs flag the cycle whose closing clk edge makes
//                the falling / rising SPI clock transition.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_spi_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_sclk,
    output logic o_fall_tick,
    output logic o_rise_tick
);

    localparam int                c_cnt_w    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sclk;
    logic               w_last;

    // Last cycle of the current half-period
    assign w_last      = i_en && (r_cnt == c_cnt_last);
    assign o_fall_tick = w_last &&  r_sclk;
    assign o_rise_tick = w_last && !r_sclk;
    assign o_sclk      = r_sclk;

    // Half-period counter; SPI clock parks high whenever not enabled
    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else if (w_last) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx
//  Description : Serialises one DDS sample per SPI frame to a DAC7512 /
//                AD5620-style DAC (SYNC_n framed, MSB first, data sampled on
//                the falling SPI clock edge). Single-entry valid/ready input.
//                Build option DAC_SPI_OFFSET_BIN_EN: treat the sample as two's
//                complement and invert its MSB to get offset binary.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_spi_tx
    import dds_pkg::*;
#(
    parameter int                  DAC_WIDTH     = DAC_WIDTH_DEF,
    parameter int                  CMD_BITS      = CMD_BITS_DEF,
    parameter logic [CMD_BITS-1:0] CMD_VAL       = CMD_BITS'(CMD_NORMAL),
    parameter int                  SCLK_DIV      = 2,
    parameter int                  SYNC_HIGH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DAC_WIDTH-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 dac_sclk,
    output logic                 dac_sync_n,
    output logic                 dac_sdo,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int FRAME_BITS = frame_bits(CMD_BITS, DAC_WIDTH);
    localparam int c_bit_w    = $clog2(FRAME_BITS);
    localparam int c_hold_w   = (SYNC_HIGH_CYC > 1) ? $clog2(SYNC_HIGH_CYC) : 1;

    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(FRAME_BITS - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(SYNC_HIGH_CYC - 1);

    logic [1:0]            r_state;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic                  r_last;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic                  r_ready;
    logic                  r_sync_n;
    logic                  r_frame_done;

    logic [DAC_WIDTH-1:0]  w_sample;
    logic                  w_accept;
    logic                  w_sclk_en;
    logic                  w_sclk;
    logic                  w_fall;
    logic                  w_rise;

`ifdef DAC_SPI_OFFSET_BIN_EN
    // Two's complement in, offset binary out: flip the sign bit
    assign w_sample = {~sample_data[DAC_WIDTH-1], sample_data[DAC_WIDTH-2:0]};
`else
    assign w_sample = sample_data;
`endif

    // r_ready is only ever set in IDLE, so it alone qualifies the handshake
    assign w_accept  = sample_valid && r_ready;
    assign w_sclk_en = (r_state == ST_SHIFT);

    dac_spi_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept),
        .i_en        (w_sclk_en),
        .o_sclk      (w_sclk),
        .o_fall_tick (w_fall),
        .o_rise_tick (w_rise)
    );

    assign sample_ready = r_ready;
    assign dac_sclk     = w_sclk;
    assign dac_sync_n   = r_sync_n;
    // Shift register empties to zero after the last bit, so SDO idles low
    assign dac_sdo      = r_shreg[FRAME_BITS-1];
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;

    // Frame FSM: accept, shift out MSB first, hold SYNC_n high, return to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_last       <= 1'b0;
            r_hold_cnt   <= '0;
            r_ready      <= 1'b0;
            r_sync_n     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_shreg   <= {CMD_VAL, w_sample};
                        r_bit_cnt <= '0;
                        r_last    <= 1'b0;
                        r_ready   <= 1'b0;
                        r_sync_n  <= 1'b0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Count DAC sampling edges; flag the final bit instead of wrapping
                    if (w_fall) begin
                        if (r_bit_cnt == c_bit_last) begin
                            r_last <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    // New bit appears together with the rising SPI clock edge
                    if (w_rise) begin
                        r_shreg <= r_shreg << 1;
                        if (r_last) begin
                            r_sync_n     <= 1'b1;
                            r_frame_done <= 1'b1;
                            r_hold_cnt   <= '0;
                            r_state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_tx
//  Description : Self-checking bench for dac_spi_tx. Two instances: default
//                timing and the fastest timing (SCLK_DIV=1, SYNC_HIGH_CYC=1).
//                A DAC-side model captures frames from the SPI pins.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_spi_tx;

    localparam int c_fb   = 16;
    localparam int c_len0 = c_fb * 2 * 2;
    localparam int c_len1 = c_fb * 2 * 1;
    localparam int c_per0 = 1 + c_len0 + 2;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [11:0] data0  = '0;
    logic [11:0] data1  = '0;
    logic        valid0 = 1'b0;
    logic        valid1 = 1'b0;
    logic        ready0, sclk0, sync0, sdo0, busy0, done0;
    logic        ready1, sclk1, sync1, sdo1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    // DAC-side model state, one slot per instance
    logic        p_sclk [2];
    logic        p_sync [2];
    logic        p_sdo  [2];
    logic        p_ready[2];
    logic [31:0] sh     [2];
    int nb[2], lowlen[2], good[2], aborted[2], dones[2];
    int stab_err[2], proto_err[2], done_err[2];
    int last_len[2], gap[2], rise_cyc[2];
    bit rise_pend[2];

    logic [15:0] capq0[$], capq1[$], expq0[$], expq1[$];
    int          stq0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx #(.DAC_WIDTH(12), .CMD_BITS(4), .CMD_VAL(4'b0000),
                 .SCLK_DIV(2), .SYNC_HIGH_CYC(2)) u_dut0 (
        .clk(clk), .rst(rst), .sample_data(data0), .sample_valid(valid0),
        .sample_ready(ready0), .dac_sclk(sclk0), .dac_sync_n(sync0),
        .dac_sdo(sdo0), .busy(busy0), .frame_done(done0));

    dac_spi_tx #(.DAC_WIDTH(12), .CMD_BITS(4), .CMD_VAL(4'b0000),
                 .SCLK_DIV(1), .SYNC_HIGH_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .sample_data(data1), .sample_valid(valid1),
        .sample_ready(ready1), .dac_sclk(sclk1), .dac_sync_n(sync1),
        .dac_sdo(sdo1), .busy(busy1), .frame_done(done1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Word the DAC should receive for a given sample
    function automatic logic [15:0] exp_word(input logic [11:0] s);
`ifdef DAC_SPI_OFFSET_BIN_EN
        logic [11:0] off;
        off = s + 12'h800;
        return {4'h0, off};
`else
        return {4'h0, s};
`endif
    endfunction

    // DAC model: shift SDO in on every SCLK fall while SYNC_n is low
    task automatic mon(input int m, input logic sclk, input logic sync, input logic sdo,
                       input logic ready, input logic done, input logic busy);
        if (p_sync[m] && !sync) begin
            nb[m] = 0; sh[m] = '0; lowlen[m] = 0;
            if (m == 0) stq0.push_back(cyc);
        end
        if (!sync) begin
            lowlen[m]++;
            if (!sclk && !p_sclk[m] && (sdo !== p_sdo[m])) stab_err[m]++;
            if (p_sclk[m] && !sclk) begin
                if (sdo !== p_sdo[m]) stab_err[m]++;
                sh[m] = {sh[m][30:0], sdo};
                nb[m]++;
            end
        end else begin
            if (sclk !== 1'b1 || sdo !== 1'b0) proto_err[m]++;
        end
        if (ready && busy) proto_err[m]++;
        if (!p_sync[m] && sync) begin
            if (nb[m] == c_fb) begin
                good[m]++;
                last_len[m] = lowlen[m];
                if (!done) done_err[m]++;
                if (m == 0) capq0.push_back(sh[m][15:0]);
                else        capq1.push_back(sh[m][15:0]);
                rise_cyc[m]  = cyc;
                rise_pend[m] = 1'b1;
            end else begin
                aborted[m]++;
            end
        end
        if (done) dones[m]++;
        if (ready && !p_ready[m] && rise_pend[m]) begin
            gap[m]       = cyc - rise_cyc[m];
            rise_pend[m] = 1'b0;
        end
        p_sclk[m] = sclk; p_sync[m] = sync; p_sdo[m] = sdo; p_ready[m] = ready;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, sclk0, sync0, sdo0, ready0, done0, busy0);
            mon(1, sclk1, sync1, sdo1, ready1, done1, busy1);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic rdy(input int m);
        return (m == 0) ? ready0 : ready1;
    endfunction

    task automatic wait_ready(input int m);
        int t = 0;
        while (rdy(m) !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        chk("wait_ready", 32'(rdy(m)), 32'd1);
    endtask

    task automatic send(input int m, input logic [11:0] d, input bit expect_ok);
        wait_ready(m);
        if (m == 0) begin data0 = d; valid0 = 1'b1; end
        else        begin data1 = d; valid1 = 1'b1; end
        if (expect_ok) begin
            if (m == 0) expq0.push_back(exp_word(d));
            else        expq1.push_back(exp_word(d));
        end
        tick();
        if (m == 0) begin valid0 = 1'b0; data0 = 12'($urandom); end
        else        begin valid1 = 1'b0; data1 = 12'($urandom); end
    endtask

    task automatic wait_frames(input int m, input int target);
        int t = 0;
        while (good[m] < target && t < 3000) begin
            tick();
            t++;
        end
        chk("frame_wait", 32'(good[m] >= target), 32'd1);
    endtask

    task automatic pop_cmp(input int m, output logic [15:0] got);
        logic [15:0] e;
        got = 'x;
        if (m == 0) begin
            if (capq0.size() > 0 && expq0.size() > 0) begin
                got = capq0.pop_front(); e = expq0.pop_front();
                chk("word0", 32'(got), 32'(e));
            end else chk("capq0_empty", capq0.size(), 32'd1);
        end else begin
            if (capq1.size() > 0 && expq1.size() > 0) begin
                got = capq1.pop_front(); e = expq1.pop_front();
                chk("word1", 32'(got), 32'(e));
            end else chk("capq1_empty", capq1.size(), 32'd1);
        end
    endtask

    // One complete frame: send, capture, compare word, SYNC_n low time, ready gap
    task automatic frame(input int m, input logic [11:0] d, output logic [15:0] got);
        int g0;
        g0 = good[m];
        send(m, d, 1'b1);
        wait_frames(m, g0 + 1);
        pop_cmp(m, got);
        chk("sync_low_len", last_len[m], (m == 0) ? c_len0 : c_len1);
        wait_ready(m);
        chk("ready_gap", gap[m], (m == 0) ? 32'd2 : 32'd1);
    endtask

    initial begin
        logic [15:0] got;
        int          d0, g0, a0, n, t;
        for (int i = 0; i < 2; i++) begin
            p_sclk[i] = 1'b1; p_sync[i] = 1'b1; p_sdo[i] = 1'b0; p_ready[i] = 1'b0;
            sh[i] = '0; nb[i] = 0; lowlen[i] = 0; good[i] = 0; aborted[i] = 0;
            dones[i] = 0; stab_err[i] = 0; proto_err[i] = 0; done_err[i] = 0;
            last_len[i] = 0; gap[i] = 0; rise_cyc[i] = 0; rise_pend[i] = 1'b0;
        end

        // Reset values
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_ready",  32'(ready0), 32'd0);
        chk("rst_sclk",   32'(sclk0),  32'd1);
        chk("rst_sync_n", 32'(sync0),  32'd1);
        chk("rst_sdo",    32'(sdo0),   32'd0);
        chk("rst_busy",   32'(busy0),  32'd0);
        chk("rst_done",   32'(done0),  32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(ready0), 32'd1);

        // Single frame of 0xABC
        d0 = dones[0];
        frame(0, 12'hABC, got);
`ifdef DAC_SPI_OFFSET_BIN_EN
        chk("t1_word", 32'(got), 32'h02BC);
`else
        chk("t1_word", 32'(got), 32'h0ABC);
`endif
        chk("t1_done_pulses", dones[0] - d0, 32'd1);

        // Valid held high, data 0..4, one accept per frame period
        stq0.delete();
        g0 = good[0];
        n  = 0;
        t  = 0;
        while (n < 5 && t < 1000) begin
            if (ready0) begin
                data0  = 12'(n);
                valid0 = 1'b1;
                expq0.push_back(exp_word(12'(n)));
                n++;
            end
            tick();
            t++;
        end
        valid0 = 1'b0;
        wait_frames(0, g0 + 5);
        repeat (4) tick();
        chk("t2_nframes", stq0.size(), 32'd5);
        for (int i = 1; i < stq0.size(); i++) chk("t2_period", stq0[i] - stq0[i-1], c_per0);
        for (int i = 0; i < 5; i++) pop_cmp(0, got);

        // Valid pulsed while busy is ignored
        g0 = good[0];
        send(0, 12'($urandom), 1'b1);
        repeat (10) tick();
        chk("t3_ready_busy", 32'(ready0), 32'd0);
        chk("t3_busy",       32'(busy0),  32'd1);
        data0 = 12'h555; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        wait_frames(0, g0 + 1);
        pop_cmp(0, got);
        frame(0, 12'($urandom), got);
        repeat (80) tick();
        chk("t3_frame_count", good[0] - g0, 32'd2);

        // Reset in the middle of a frame
        g0 = good[0];
        a0 = aborted[0];
        send(0, 12'($urandom), 1'b0);
        t = 0;
        while (nb[0] < 7 && t < 200) begin
            tick();
            t++;
        end
        chk("t4_reach_bit7", nb[0], 32'd7);
        rst = 1'b1; valid0 = 1'b1; data0 = 12'($urandom);
        tick();
        rst = 1'b0; valid0 = 1'b0;
        chk("t4_sync_n", 32'(sync0),  32'd1);
        chk("t4_sclk",   32'(sclk0),  32'd1);
        chk("t4_sdo",    32'(sdo0),   32'd0);
        chk("t4_ready",  32'(ready0), 32'd0);
        chk("t4_busy",   32'(busy0),  32'd0);
        repeat (5) tick();
        chk("t4_no_start", 32'(busy0), 32'd0);
        chk("t4_aborted",  aborted[0] - a0, 32'd1);
        chk("t4_no_good",  good[0] - g0, 32'd0);
        frame(0, 12'h123, got);

        // Offset-binary corner samples
        frame(0, 12'h800, got);
`ifdef DAC_SPI_OFFSET_BIN_EN
        chk("t6_800", 32'(got), 32'h0000);
`else
        chk("t6_800", 32'(got), 32'h0800);
`endif
        frame(0, 12'h7FF, got);
`ifdef DAC_SPI_OFFSET_BIN_EN
        chk("t6_7ff", 32'(got), 32'h0FFF);
`else
        chk("t6_7ff", 32'(got), 32'h07FF);
`endif

        // Random samples with random idle gaps
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            frame(0, (i == 0) ? 12'h000 : (i == 1) ? 12'hFFF : 12'($urandom), got);
        end

        // Fastest timing instance
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            frame(1, 12'($urandom), got);
        end

        repeat (10) tick();
        chk("sdo_stable0",  stab_err[0],  32'd0);
        chk("sdo_stable1",  stab_err[1],  32'd0);
        chk("idle_pins0",   proto_err[0], 32'd0);
        chk("idle_pins1",   proto_err[1], 32'd0);
        chk("done_at_end0", done_err[0],  32'd0);
        chk("done_at_end1", done_err[1],  32'd0);
        chk("done_count0",  dones[0], good[0]);
        chk("done_count1",  dones[1], good[1]);
        chk("leftover_cap0", capq0.size() + expq0.size(), 32'd0);
        chk("leftover_cap1", capq1.size() + expq1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
